// File: rtl/cond_flag_reader_if.sv
// Request/response handshake between issue logic and the condition reader.
// The master issues a condition and consumes the result; the slave is the reader.
interface cond_flag_reader_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_cond;
    logic       out_valid;
    logic       out_ready;
    logic       out_exec;
    logic [3:0] out_cond;

    modport master (
        output in_valid,
        output in_cond,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_exec,
        input  out_cond
    );

    modport slave (
        input  in_valid,
        input  in_cond,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_exec,
        output out_cond
    );
endinterface

// File: rtl/cond_flag_reader.sv
// Evaluates one ARM condition field against NZCV once every in-flight
// flag-setting instruction has committed, tracked by a saturating scoreboard.
module cond_flag_reader #(
    parameter int PEND_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           status_bits_in,
    input  logic                 wr_issue,
    input  logic                 wr_commit,
    input  logic                 flush,
    output logic                 err,
    cond_flag_reader_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [3:0]        COND_AL   = 4'b1110;

    state_t            state_q;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              err_q, err_d;
    logic [3:0]        cond_q;
    logic              out_valid_q;
    logic              out_exec_q;
    logic [3:0]        out_cond_q;

    logic issue_only;
    logic commit_only;
    logic flags_ready;
    logic accept;

    // Pairs share a base predicate; the low bit inverts it (AL/1111 included).
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, base;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ cond[0];
    endfunction

    assign issue_only  = wr_issue & ~wr_commit;
    assign commit_only = wr_commit & ~wr_issue;

    // The status register writes on the negedge, so a commit this cycle is
    // already visible on status_bits_in at the next posedge.
    assign flags_ready = (pend_q == PEND_ZERO) || ((pend_q == PEND_ONE) && commit_only);

    assign accept = bus.in_valid && (state_q == ST_IDLE);

    always_comb begin
        pend_d = pend_q;
        err_d  = err_q;
        if (flush) begin
            pend_d = PEND_ZERO;
        end else if (issue_only) begin
            if (pend_q == PEND_MAX) begin
                err_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end else if (commit_only) begin
            if (pend_q == PEND_ZERO) begin
                err_d = 1'b1;
            end else begin
                pend_d = pend_q - PEND_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= PEND_ZERO;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cond_q      <= 4'b0000;
            out_valid_q <= 1'b0;
            out_exec_q  <= 1'b0;
            out_cond_q  <= 4'b0000;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if ((bus.in_cond == COND_AL) || flags_ready) begin
                            out_exec_q  <= cond_eval(bus.in_cond, status_bits_in);
                            out_cond_q  <= bus.in_cond;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end else begin
                            cond_q  <= bus.in_cond;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (flags_ready) begin
                        out_exec_q  <= cond_eval(cond_q, status_bits_in);
                        out_cond_q  <= cond_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_exec  = out_exec_q;
    assign bus.out_cond  = out_cond_q;
    assign err           = err_q;
endmodule

// File: tb/tb_cond_flag_reader.sv
// Directed bench for cond_flag_reader: hand-computed vectors checked on the
// negedge after each driving posedge.
module tb_cond_flag_reader;
    logic       clk;
    logic       rst_n;
    logic [3:0] status_bits_in;
    logic       wr_issue;
    logic       wr_commit;
    logic       flush;
    logic       err;
    int         n_vec;
    int         n_err;

    cond_flag_reader_if bus ();

    cond_flag_reader #(.PEND_W(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .status_bits_in (status_bits_in),
        .wr_issue       (wr_issue),
        .wr_commit      (wr_commit),
        .flush          (flush),
        .err            (err),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic e, input logic [3:0] c);
        chk({tag, ".valid"}, {7'd0, bus.out_valid}, {7'd0, v});
        chk({tag, ".exec"},  {7'd0, bus.out_exec},  {7'd0, e});
        chk({tag, ".cond"},  {4'd0, bus.out_cond},  {4'd0, c});
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic request(input logic [3:0] c);
        bus.in_valid = 1'b1;
        bus.in_cond  = c;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        status_bits_in = 4'b0100;
        wr_issue = 1'b0;
        wr_commit = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_cond = 4'b0000;
        bus.out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk_out("rst", 1'b0, 1'b0, 4'b0000);
        chk("rst.err", {7'd0, err}, 8'd0);
        chk("rst.in_ready", {7'd0, bus.in_ready}, 8'd1);
        chk("rst.pend", {6'd0, dut.pend_q}, 8'd0);
        rst_n = 1'b1;
        tick();
        chk("rst.in_ready_after", {7'd0, bus.in_ready}, 8'd1);

        // EQ with Z=1, then NE
        request(4'b0000);
        chk_out("eq", 1'b1, 1'b1, 4'b0000);
        chk("eq.in_ready", {7'd0, bus.in_ready}, 8'd0);
        handshake();
        chk("eq.drop", {7'd0, bus.out_valid}, 8'd0);
        chk("eq.idle", {7'd0, bus.in_ready}, 8'd1);
        request(4'b0001);
        chk_out("ne", 1'b1, 1'b0, 4'b0001);
        handshake();

        // Two outstanding writes; GE waits for both commits
        wr_issue = 1'b1;
        tick();
        tick();
        wr_issue = 1'b0;
        chk("ge.pend2", {6'd0, dut.pend_q}, 8'd2);
        status_bits_in = 4'b1000;
        request(4'b1010);
        chk("ge.wait0.in_ready", {7'd0, bus.in_ready}, 8'd0);
        chk("ge.wait0.valid", {7'd0, bus.out_valid}, 8'd0);
        tick();
        chk("ge.wait1.valid", {7'd0, bus.out_valid}, 8'd0);
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        chk("ge.commit1.valid", {7'd0, bus.out_valid}, 8'd0);
        chk("ge.commit1.pend", {6'd0, dut.pend_q}, 8'd1);
        wr_commit = 1'b1;
        status_bits_in = 4'b1001;
        tick();
        wr_commit = 1'b0;
        chk_out("ge.done", 1'b1, 1'b1, 4'b1010);
        chk("ge.done.pend", {6'd0, dut.pend_q}, 8'd0);
        handshake();

        // AL bypasses the scoreboard
        wr_issue = 1'b1;
        tick();
        wr_issue = 1'b0;
        request(4'b1110);
        chk_out("al", 1'b1, 1'b1, 4'b1110);
        chk("al.pend", {6'd0, dut.pend_q}, 8'd1);
        handshake();

        // Simultaneous issue+commit in WAIT leaves pend unchanged
        request(4'b0000);
        chk("both.wait.in_ready", {7'd0, bus.in_ready}, 8'd0);
        wr_issue = 1'b1;
        wr_commit = 1'b1;
        tick();
        wr_issue = 1'b0;
        wr_commit = 1'b0;
        chk("both.pend", {6'd0, dut.pend_q}, 8'd1);
        chk("both.valid", {7'd0, bus.out_valid}, 8'd0);
        chk("both.in_ready", {7'd0, bus.in_ready}, 8'd0);
        wr_commit = 1'b1;
        status_bits_in = 4'b0100;
        tick();
        wr_commit = 1'b0;
        chk_out("both.done", 1'b1, 1'b1, 4'b0000);
        handshake();

        // Underflow then overflow
        chk("uf.err_before", {7'd0, err}, 8'd0);
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        chk("uf.err", {7'd0, err}, 8'd1);
        chk("uf.pend", {6'd0, dut.pend_q}, 8'd0);
        wr_issue = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        wr_issue = 1'b0;
        chk("of.pend", {6'd0, dut.pend_q}, 8'd3);
        chk("of.err", {7'd0, err}, 8'd1);

        // Flush out of WAIT with pend=2
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        chk("fl.pend2", {6'd0, dut.pend_q}, 8'd2);
        request(4'b0011);
        chk("fl.wait", {7'd0, bus.in_ready}, 8'd0);
        flush = 1'b1;
        wr_issue = 1'b1;
        tick();
        flush = 1'b0;
        wr_issue = 1'b0;
        chk("fl.in_ready", {7'd0, bus.in_ready}, 8'd1);
        chk("fl.valid", {7'd0, bus.out_valid}, 8'd0);
        chk("fl.pend", {6'd0, dut.pend_q}, 8'd0);
        chk("fl.err_kept", {7'd0, err}, 8'd1);

        // Flush beats a same-cycle accept
        bus.in_valid = 1'b1;
        bus.in_cond = 4'b1110;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_acc.valid", {7'd0, bus.out_valid}, 8'd0);
        chk("fl_acc.in_ready", {7'd0, bus.in_ready}, 8'd1);

        // CC with C=0, outputs stable while back-pressured
        status_bits_in = 4'b0000;
        request(4'b0011);
        chk_out("cc", 1'b1, 1'b1, 4'b0011);
        status_bits_in = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("hold", 1'b1, 1'b1, 4'b0011);
        end
        handshake();

        // LE with Z=0, N!=V; LS with C=1,Z=0
        status_bits_in = 4'b1010;
        request(4'b1101);
        chk_out("le", 1'b1, 1'b1, 4'b1101);
        handshake();
        request(4'b1001);
        chk_out("ls", 1'b1, 1'b0, 4'b1001);
        handshake();
        request(4'b1111);
        chk_out("nv", 1'b1, 1'b0, 4'b1111);

        // Asynchronous reset while holding a result
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst", 1'b0, 1'b0, 4'b0000);
        chk("arst.err", {7'd0, err}, 8'd0);
        chk("arst.in_ready", {7'd0, bus.in_ready}, 8'd1);
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
